// File: rtl/half_adder_checker.sv
// Response checker for a half adder: aligns applied vectors with the DUT response,
// scores each check against c=a&b, s=a^b, and keeps pass/fail statistics and coverage.
module half_adder_checker #(
    parameter int CNT_W   = 8,
    parameter int LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             vld_i,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             c_i,
    input  logic             s_i,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             err_o,
    output logic [3:0]       first_fail_o,
    output logic [3:0]       cov_o,
    output logic             done_o,
    output logic [1:0]       state_o
);
    // state | meaning
    // IDLE  | no check since reset/clear
    // RUN   | every check so far matched
    // ERR   | at least one mismatch seen; held until clear or reset

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic al_vld;
    logic al_a;
    logic al_b;

    generate
        if (LATENCY == 0) begin : g_bypass
            assign al_vld = vld_i;
            assign al_a   = a_i;
            assign al_b   = b_i;
        end else begin : g_pipe
            logic [2:0] pipe_q [LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) pipe_q[i] <= 3'b000;
                end else if (clr_i) begin
                    for (int i = 0; i < LATENCY; i++) pipe_q[i] <= 3'b000;
                end else begin
                    pipe_q[0] <= {vld_i, a_i, b_i};
                    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign al_vld = pipe_q[LATENCY-1][2];
            assign al_a   = pipe_q[LATENCY-1][1];
            assign al_b   = pipe_q[LATENCY-1][0];
        end
    endgenerate

    logic exp_c;
    logic exp_s;
    logic match;

    assign exp_c = al_a & al_b;
    assign exp_s = al_a ^ al_b;
    assign match = (c_i == exp_c) && (s_i == exp_s);

    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;
    logic             err_q;
    logic [3:0]       first_fail_q;
    logic [3:0]       cov_q;
    state_t           state_q;
    state_t           state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q       <= '0;
            fail_q       <= '0;
            err_q        <= 1'b0;
            first_fail_q <= 4'b0000;
            cov_q        <= 4'b0000;
        end else if (clr_i) begin
            pass_q       <= '0;
            fail_q       <= '0;
            err_q        <= 1'b0;
            first_fail_q <= 4'b0000;
            cov_q        <= 4'b0000;
        end else if (al_vld) begin
            cov_q[{al_a, al_b}] <= 1'b1;
            if (match) begin
                if (pass_q != CNT_MAX) pass_q <= pass_q + 1'b1;
            end else begin
                if (fail_q != CNT_MAX) fail_q <= fail_q + 1'b1;
                // Only the first mismatch since reset/clear is captured.
                if (!err_q) first_fail_q <= {al_a, al_b, c_i, s_i};
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (al_vld) state_d = match ? RUN : ERR;
                RUN:     if (al_vld && !match) state_d = ERR;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    assign pass_cnt_o   = pass_q;
    assign fail_cnt_o   = fail_q;
    assign err_o        = err_q;
    assign first_fail_o = first_fail_q;
    assign cov_o        = cov_q;
    assign done_o       = (cov_q == 4'b1111) && !err_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_half_adder_checker.sv
// Directed bench for half_adder_checker: four instances cover LATENCY 0/2/3 and a
// narrow-counter build; each task drives its scenario and checks inline.
module tb_half_adder_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // LATENCY=0, CNT_W=8, responses driven directly
    logic d0_v = 0, d0_a = 0, d0_b = 0, d0_c = 0, d0_s = 0;
    logic [7:0] d0_pc, d0_fc;
    logic d0_err, d0_done;
    logic [3:0] d0_ff, d0_cov;
    logic [1:0] d0_st;

    // LATENCY=2, responses from a 2-stage ideal half adder
    logic d2_v = 0, d2_a = 0, d2_b = 0, d2_c, d2_s;
    logic [1:0] d2_r1 = 0, d2_r2 = 0;
    logic [7:0] d2_pc, d2_fc;
    logic d2_err, d2_done;
    logic [3:0] d2_ff, d2_cov;
    logic [1:0] d2_st;

    // LATENCY=0, CNT_W=2
    logic ds_v = 0, ds_a = 0, ds_b = 0, ds_c = 0, ds_s = 0;
    logic [1:0] ds_pc, ds_fc;
    logic ds_err, ds_done;
    logic [3:0] ds_ff, ds_cov;
    logic [1:0] ds_st;

    // LATENCY=3, responses from a 3-stage ideal half adder that ignores rst
    logic d3_v = 0, d3_a = 0, d3_b = 0, d3_c, d3_s;
    logic [1:0] d3_r1 = 0, d3_r2 = 0, d3_r3 = 0;
    logic [7:0] d3_pc, d3_fc;
    logic d3_err, d3_done;
    logic [3:0] d3_ff, d3_cov;
    logic [1:0] d3_st;

    always @(posedge clk) begin
        d2_r1 <= {d2_a & d2_b, d2_a ^ d2_b};
        d2_r2 <= d2_r1;
        d3_r1 <= {d3_a & d3_b, d3_a ^ d3_b};
        d3_r2 <= d3_r1;
        d3_r3 <= d3_r2;
    end
    assign {d2_c, d2_s} = d2_r2;
    assign {d3_c, d3_s} = d3_r3;

    half_adder_checker #(.CNT_W(8), .LATENCY(0)) u_d0 (
        .clk(clk), .rst(rst), .clr_i(clr), .vld_i(d0_v), .a_i(d0_a), .b_i(d0_b),
        .c_i(d0_c), .s_i(d0_s), .pass_cnt_o(d0_pc), .fail_cnt_o(d0_fc), .err_o(d0_err),
        .first_fail_o(d0_ff), .cov_o(d0_cov), .done_o(d0_done), .state_o(d0_st));

    half_adder_checker #(.CNT_W(8), .LATENCY(2)) u_d2 (
        .clk(clk), .rst(rst), .clr_i(clr), .vld_i(d2_v), .a_i(d2_a), .b_i(d2_b),
        .c_i(d2_c), .s_i(d2_s), .pass_cnt_o(d2_pc), .fail_cnt_o(d2_fc), .err_o(d2_err),
        .first_fail_o(d2_ff), .cov_o(d2_cov), .done_o(d2_done), .state_o(d2_st));

    half_adder_checker #(.CNT_W(2), .LATENCY(0)) u_ds (
        .clk(clk), .rst(rst), .clr_i(clr), .vld_i(ds_v), .a_i(ds_a), .b_i(ds_b),
        .c_i(ds_c), .s_i(ds_s), .pass_cnt_o(ds_pc), .fail_cnt_o(ds_fc), .err_o(ds_err),
        .first_fail_o(ds_ff), .cov_o(ds_cov), .done_o(ds_done), .state_o(ds_st));

    half_adder_checker #(.CNT_W(8), .LATENCY(3)) u_d3 (
        .clk(clk), .rst(rst), .clr_i(clr), .vld_i(d3_v), .a_i(d3_a), .b_i(d3_b),
        .c_i(d3_c), .s_i(d3_s), .pass_cnt_o(d3_pc), .fail_cnt_o(d3_fc), .err_o(d3_err),
        .first_fail_o(d3_ff), .cov_o(d3_cov), .done_o(d3_done), .state_o(d3_st));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d0_vec(input logic a, input logic b, input logic c, input logic s);
        d0_v = 1'b1; d0_a = a; d0_b = b; d0_c = c; d0_s = s;
        tick();
        d0_v = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({d0_pc, d0_fc, d0_err, d0_ff, d0_cov, d0_done, d0_st} !== 23'd0) begin
            errors++;
            $display("FAIL reset_d0 got pc=%0d fc=%0d err=%0b ff=%b cov=%b done=%0b st=%0d exp all zero",
                     d0_pc, d0_fc, d0_err, d0_ff, d0_cov, d0_done, d0_st);
        end
        checks++;
        if ({d3_pc, d3_fc, d3_err, d3_cov, d3_st} !== 23'd0) begin
            errors++;
            $display("FAIL reset_d3 got pc=%0d fc=%0d err=%0b cov=%b st=%0d exp all zero",
                     d3_pc, d3_fc, d3_err, d3_cov, d3_st);
        end
    endtask

    task automatic test_back_to_back();
        d0_v = 1'b1;
        d0_a = 0; d0_b = 0; d0_c = 0; d0_s = 0; tick();
        d0_a = 0; d0_b = 1; d0_c = 0; d0_s = 1; tick();
        d0_a = 1; d0_b = 0; d0_c = 0; d0_s = 1; tick();
        d0_a = 1; d0_b = 1; d0_c = 1; d0_s = 0; tick();
        d0_v = 1'b0;
        tick();
        checks++;
        if (d0_pc !== 8'd4 || d0_fc !== 8'd0) begin
            errors++;
            $display("FAIL b2b_counts got pass=%0d fail=%0d exp pass=4 fail=0", d0_pc, d0_fc);
        end
        checks++;
        if (d0_cov !== 4'b1111 || d0_done !== 1'b1 || d0_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cov_done got cov=%b done=%0b err=%0b exp cov=1111 done=1 err=0",
                     d0_cov, d0_done, d0_err);
        end
        checks++;
        if (d0_st !== 2'd1) begin
            errors++;
            $display("FAIL b2b_state got %0d exp 1", d0_st);
        end
    endtask

    task automatic test_first_fail();
        clr = 1'b1; tick(); clr = 1'b0;
        d0_vec(1, 1, 0, 0);
        d0_vec(0, 1, 0, 1);
        tick();
        checks++;
        if (d0_fc !== 8'd1 || d0_pc !== 8'd1 || d0_err !== 1'b1) begin
            errors++;
            $display("FAIL ff_counts got fail=%0d pass=%0d err=%0b exp 1 1 1", d0_fc, d0_pc, d0_err);
        end
        checks++;
        if (d0_ff !== 4'b1100 || d0_st !== 2'd2 || d0_done !== 1'b0) begin
            errors++;
            $display("FAIL ff_capture got ff=%b st=%0d done=%0b exp ff=1100 st=2 done=0",
                     d0_ff, d0_st, d0_done);
        end
        checks++;
        if (d0_cov !== 4'b1010) begin
            errors++;
            $display("FAIL ff_cov got %b exp 1010", d0_cov);
        end
        d0_vec(1, 0, 1, 1);
        d0_vec(1, 1, 1, 1);
        tick();
        checks++;
        if (d0_fc !== 8'd3 || d0_ff !== 4'b1100 || d0_st !== 2'd2) begin
            errors++;
            $display("FAIL ff_hold got fail=%0d ff=%b st=%0d exp fail=3 ff=1100 st=2",
                     d0_fc, d0_ff, d0_st);
        end
    endtask

    task automatic test_clr_priority();
        clr = 1'b1; tick(); clr = 1'b0;
        d0_vec(0, 0, 0, 0);
        checks++;
        if (d0_pc !== 8'd1 || d0_st !== 2'd1) begin
            errors++;
            $display("FAIL clr_setup got pass=%0d st=%0d exp 1 1", d0_pc, d0_st);
        end
        clr = 1'b1;
        d0_vec(1, 0, 0, 0);
        clr = 1'b0;
        checks++;
        if ({d0_pc, d0_fc, d0_err, d0_ff, d0_cov, d0_st} !== 26'd0) begin
            errors++;
            $display("FAIL clr_same_edge got pc=%0d fc=%0d err=%0b ff=%b cov=%b st=%0d exp all zero",
                     d0_pc, d0_fc, d0_err, d0_ff, d0_cov, d0_st);
        end
        d0_vec(1, 0, 0, 1);
        checks++;
        if (d0_pc !== 8'd1 || d0_fc !== 8'd0 || d0_st !== 2'd1 || d0_cov !== 4'b0100) begin
            errors++;
            $display("FAIL clr_after got pc=%0d fc=%0d st=%0d cov=%b exp 1 0 1 0100",
                     d0_pc, d0_fc, d0_st, d0_cov);
        end
    endtask

    task automatic test_latency();
        logic [1:0] vecs [4];
        vecs[0] = 2'b00; vecs[1] = 2'b01; vecs[2] = 2'b10; vecs[3] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            d2_v = 1'b1; {d2_a, d2_b} = vecs[k];
            tick();
            d2_v = 1'b0; d2_a = ~d2_a; d2_b = 1'b1;
            tick();
            checks++;
            if (d2_pc !== 8'(k) || d2_fc !== 8'd0) begin
                errors++;
                $display("FAIL lat_early k=%0d got pass=%0d fail=%0d exp pass=%0d fail=0",
                         k, d2_pc, d2_fc, k);
            end
            tick();
            checks++;
            if (d2_pc !== 8'(k + 1) || d2_fc !== 8'd0) begin
                errors++;
                $display("FAIL lat_check k=%0d got pass=%0d fail=%0d exp pass=%0d fail=0",
                         k, d2_pc, d2_fc, k + 1);
            end
        end
        repeat (3) tick();
        checks++;
        if (d2_pc !== 8'd4 || d2_fc !== 8'd0 || d2_cov !== 4'b1111 || d2_done !== 1'b1) begin
            errors++;
            $display("FAIL lat_final got pass=%0d fail=%0d cov=%b done=%0b exp 4 0 1111 1",
                     d2_pc, d2_fc, d2_cov, d2_done);
        end
    endtask

    task automatic test_saturation();
        ds_v = 1'b1; ds_a = 1; ds_b = 1; ds_c = 1; ds_s = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (ds_pc !== ((k < 3) ? 2'(k) : 2'd3)) begin
                errors++;
                $display("FAIL sat_pass k=%0d got %0d exp %0d", k, ds_pc, (k < 3) ? k : 3);
            end
        end
        ds_a = 0; ds_b = 0; ds_c = 1; ds_s = 0;
        tick();
        ds_v = 1'b0;
        tick();
        checks++;
        if (ds_pc !== 2'd3 || ds_fc !== 2'd1 || ds_err !== 1'b1 || ds_ff !== 4'b0010) begin
            errors++;
            $display("FAIL sat_fail got pass=%0d fail=%0d err=%0b ff=%b exp 3 1 1 0010",
                     ds_pc, ds_fc, ds_err, ds_ff);
        end
    endtask

    task automatic test_async_reset();
        d3_v = 1'b1; d3_a = 0; d3_b = 0;
        tick();
        d3_v = 1'b0;
        repeat (3) tick();
        checks++;
        if (d3_pc !== 8'd1 || d3_st !== 2'd1 || d3_cov !== 4'b0001) begin
            errors++;
            $display("FAIL ar_setup got pass=%0d st=%0d cov=%b exp 1 1 0001", d3_pc, d3_st, d3_cov);
        end
        d3_v = 1'b1; d3_a = 1; d3_b = 1; tick();
        d3_a = 0; d3_b = 1; tick();
        d3_v = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({d3_pc, d3_fc, d3_err, d3_ff, d3_cov, d3_done, d3_st} !== 23'd0) begin
            errors++;
            $display("FAIL ar_immediate got pc=%0d fc=%0d err=%0b ff=%b cov=%b done=%0b st=%0d exp all zero",
                     d3_pc, d3_fc, d3_err, d3_ff, d3_cov, d3_done, d3_st);
        end
        #1 rst = 1'b0;
        repeat (5) tick();
        checks++;
        if ({d3_pc, d3_fc, d3_err, d3_cov, d3_st} !== 23'd0) begin
            errors++;
            $display("FAIL ar_stale got pc=%0d fc=%0d err=%0b cov=%b st=%0d exp all zero",
                     d3_pc, d3_fc, d3_err, d3_cov, d3_st);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_first_fail();
        test_clr_priority();
        test_latency();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
